// File: rtl/leglite_pkg.sv
// Shared LEGLite pipeline types and constants.
// Used by the fetch stage and its next-PC helper.
package leglite_pkg;

    localparam int INSTR_W = 17;
    localparam int ADDR_W  = 16;

    localparam logic [3:0] OPC_J = 4'd8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 17'd0;

    typedef struct packed {
        logic              valid;
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_plus2;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{
        valid:    1'b0,
        instr:    NOP_INSTR,
        pc_plus2: '0
    };

    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        return instr[16:13] == OPC_J;
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the fetch stage.
// Early jump decode is built in when FETCH_EARLY_JUMP_EN is defined.
module fetch_next_pc
    import leglite_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] idata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               stall,
    output logic [ADDR_W-1:0]  pc_plus2,
    output logic [ADDR_W-1:0]  next_pc
);

    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;

    assign pc_plus2 = pc + 16'd2;
    assign target   = {redirect_addr[15:1], 1'b0};

`ifdef FETCH_EARLY_JUMP_EN
    // Jump target is a word index, so it is shifted into a byte address.
    assign seq_pc = is_jump(idata)
                  ? {2'b00, idata[12:0], 1'b0}
                  : pc_plus2;
`else
    logic unused_idata;
    assign unused_idata = ^idata;
    assign seq_pc       = pc_plus2;
`endif

    always_comb begin
        next_pc = seq_pc;
        unique case (1'b1)
            redirect_valid:          next_pc = target;
            !redirect_valid && stall: next_pc = pc;
            default:                 next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGLite instruction fetch: PC register and IF/ID pipeline register.
// Optional zero-bubble jump resolution via FETCH_EARLY_JUMP_EN.
module fetch_stage
    import leglite_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  iaddr,
    input  logic [INSTR_W-1:0] idata,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               ifid_valid,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus2
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_plus2;
    ifid_t             ifid_q;
    ifid_t             ifid_d;

    fetch_next_pc u_next_pc (
        .pc             (pc_q),
        .idata          (idata),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .stall          (stall),
        .pc_plus2       (pc_plus2),
        .next_pc        (pc_d)
    );

    // Flush beats stall for IF/ID; the PC side is handled in fetch_next_pc.
    always_comb begin
        ifid_d = ifid_q;
        unique case (1'b1)
            redirect_valid: ifid_d = IFID_BUBBLE;
            !redirect_valid && flush: ifid_d = IFID_BUBBLE;
            !redirect_valid && !flush && stall: ifid_d = ifid_q;
            !redirect_valid && !flush && !stall: begin
                ifid_d.valid    = 1'b1;
                ifid_d.instr    = idata;
                ifid_d.pc_plus2 = pc_plus2;
            end
            default: ifid_d = ifid_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            ifid_q <= IFID_BUBBLE;
        end else begin
            pc_q   <= pc_d;
            ifid_q <= ifid_d;
        end
    end

    assign iaddr         = pc_q;
    assign ifid_valid    = ifid_q.valid;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus2 = ifid_q.pc_plus2;

endmodule
